lt_serial_cmp: RTL and testbench

LT_SERIAL_CMP -- requirements
Module: lt_serial_cmp

---
 rtl/lt_cmp_pkg.sv | 18 +
 rtl/lt_serial_cmp_if.sv | 27 ++
 rtl/lt_digit_cmp.sv | 17 +
 rtl/lt_serial_cmp.sv | 122 ++++++++++++
 tb/tb_lt_serial_cmp.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/lt_cmp_pkg.sv
// Shared encodings for the serial magnitude comparator.
package lt_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_t;

    // Result vector ordering is {lt, eq, gt}; exactly one bit set while a result is held.
    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t RES_NONE = 3'b000;
    localparam cmp_res_t RES_LT   = 3'b100;
    localparam cmp_res_t RES_EQ   = 3'b010;
    localparam cmp_res_t RES_GT   = 3'b001;

endpackage

// File: rtl/lt_serial_cmp_if.sv
// Operand/result handshake bundle for lt_serial_cmp.
interface lt_serial_cmp_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             eq;
    logic             gt;

    // Comparator side.
    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, lt, eq, gt
    );

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, lt, eq, gt
    );
endinterface

// File: rtl/lt_digit_cmp.sv
// Combinational unsigned compare of one digit.
module lt_digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             eq
);

    // Plain magnitude compare; sign handling is done by the caller.
    always_comb begin
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/lt_serial_cmp.sv
// Digit-serial comparator: scans operands MSB digit first and stops at the
// first differing digit.
module lt_serial_cmp
    import lt_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic           clk,
    input logic           rst,
    lt_serial_cmp_if.slave bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

    cmp_state_t       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    cmp_res_t         res_q, res_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic             dig_lt, dig_eq;

    // Select the current digit; in signed mode flipping the top bit of the top
    // digit turns two's-complement ordering into unsigned ordering.
    always_comb begin
        a_sh  = a_q >> (DIGIT * int'(idx_q));
        b_sh  = b_q >> (DIGIT * int'(idx_q));
        a_dig = a_sh[DIGIT-1:0];
        b_dig = b_sh[DIGIT-1:0];
        if (sgn_q && (idx_q == IDX_TOP)) begin
            a_dig[DIGIT-1] = ~a_dig[DIGIT-1];
            b_dig[DIGIT-1] = ~b_dig[DIGIT-1];
        end
    end

    lt_digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a  (a_dig),
        .b  (b_dig),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    // State register and datapath flops; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic: accept in IDLE, scan until a difference or digit 0,
    // then hold the result until the consumer takes it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sgn_d   = bus.signed_mode;
                    idx_d   = IDX_TOP;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!dig_eq) begin
                    res_d   = dig_lt ? RES_LT : RES_GT;
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    res_d   = RES_EQ;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    res_d   = RES_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                res_d   = RES_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and result outputs come straight from registered state.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.lt        = res_q[2];
        bus.eq        = res_q[1];
        bus.gt        = res_q[0];
    end

endmodule

// File: tb/tb_lt_serial_cmp.sv
module tb_lt_serial_cmp;

    logic clk;
    logic rst;

    lt_serial_cmp_if #(.WIDTH(16)) i16 ();
    lt_serial_cmp_if #(.WIDTH(4))  i4 ();

    lt_serial_cmp #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(i16));
    lt_serial_cmp #(.WIDTH(4),  .DIGIT(4)) dut4  (.clk(clk), .rst(rst), .bus(i4));

    int n_pass  = 0;
    int n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: signed/unsigned value ordering plus count of digits scanned
    // until the most significant differing digit.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input int w, input int dig,
                         output logic [2:0] res, output int k);
        longint xv, yv, diff, mask;
        int ndig;
        ndig = w / dig;
        xv = longint'(x);
        yv = longint'(y);
        if (s && x[w-1]) xv = xv - (longint'(1) << w);
        if (s && y[w-1]) yv = yv - (longint'(1) << w);
        if (xv < yv)       res = 3'b100;
        else if (xv == yv) res = 3'b010;
        else               res = 3'b001;
        diff = longint'(x ^ y);
        mask = (longint'(1) << dig) - 1;
        k = ndig;
        for (int d = ndig - 1; d >= 0; d--) begin
            if (((diff >> (d * dig)) & mask) != 0) begin
                k = ndig - d;
                break;
            end
        end
    endtask

    task automatic txn16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                         input int hold, input bit pulse, input string tag);
        logic [2:0] er;
        int ek;
        int cyc;
        model({16'h0, ta}, {16'h0, tb}, ts, 16, 4, er, ek);
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'b0, i16.in_ready}, 32'd1);
        i16.in_valid    = 1'b1;
        i16.a           = ta;
        i16.b           = tb;
        i16.signed_mode = ts;
        @(posedge clk);
        #1;
        i16.in_valid    = 1'b0;
        i16.a           = 16'($urandom);
        i16.b           = 16'($urandom);
        i16.signed_mode = 1'($urandom);
        cyc = 0;
        while (!i16.out_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(ek));
        chk({tag, "_result"}, {29'b0, i16.lt, i16.eq, i16.gt}, {29'b0, er});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (pulse) begin
                i16.in_valid = 1'b1;
                i16.a        = 16'($urandom);
                i16.b        = 16'($urandom);
            end
            @(posedge clk);
            #1;
            i16.in_valid = 1'b0;
            chk({tag, "_hold_valid"}, {31'b0, i16.out_valid}, 32'd1);
            chk({tag, "_hold_in_ready"}, {31'b0, i16.in_ready}, 32'd0);
            chk({tag, "_hold_result"}, {29'b0, i16.lt, i16.eq, i16.gt}, {29'b0, er});
        end
        @(negedge clk);
        i16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        i16.out_ready = 1'b0;
        chk({tag, "_release_valid"}, {31'b0, i16.out_valid}, 32'd0);
        chk({tag, "_release_in_ready"}, {31'b0, i16.in_ready}, 32'd1);
        chk({tag, "_release_zero"}, {29'b0, i16.lt, i16.eq, i16.gt}, 32'd0);
    endtask

    task automatic txn4(input logic [3:0] ta, input logic [3:0] tb, input logic ts, input string tag);
        logic [2:0] er;
        int ek;
        model({28'h0, ta}, {28'h0, tb}, ts, 4, 4, er, ek);
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'b0, i4.in_ready}, 32'd1);
        i4.in_valid    = 1'b1;
        i4.a           = ta;
        i4.b           = tb;
        i4.signed_mode = ts;
        @(posedge clk);
        #1;
        i4.in_valid = 1'b0;
        chk({tag, "_not_yet"}, {31'b0, i4.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_valid_lat1"}, {31'b0, i4.out_valid}, 32'(ek));
        chk({tag, "_result"}, {29'b0, i4.lt, i4.eq, i4.gt}, {29'b0, er});
        @(negedge clk);
        i4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        i4.out_ready = 1'b0;
        chk({tag, "_release_valid"}, {31'b0, i4.out_valid}, 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb, m;
        int sh;
        rst = 1'b1;
        i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.signed_mode = 1'b0; i16.out_ready = 1'b0;
        i4.in_valid  = 1'b0; i4.a  = '0; i4.b  = '0; i4.signed_mode  = 1'b0; i4.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, i16.out_valid}, 32'd0);
        chk("reset_result", {29'b0, i16.lt, i16.eq, i16.gt}, 32'd0);
        chk("reset_in_ready", {31'b0, i16.in_ready}, 32'd1);
        chk("reset_out_valid4", {31'b0, i4.out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        txn16(16'h1234, 16'h1234, 1'b0, 0, 1'b0, "eq_1234");
        txn16(16'h2000, 16'h1FFF, 1'b0, 1, 1'b0, "gt_early");
        txn16(16'h1235, 16'h1236, 1'b0, 0, 1'b0, "lt_last");
        txn16(16'h8000, 16'h0001, 1'b1, 0, 1'b0, "signed_lt");
        txn16(16'h8000, 16'h0001, 1'b0, 0, 1'b0, "unsigned_gt");
        txn16(16'hFFFF, 16'hFFFE, 1'b1, 0, 1'b0, "signed_ffff");
        txn16(16'h0F00, 16'h0E00, 1'b0, 5, 1'b1, "backpressure");

        // Reset during the second SCAN cycle of an all-equal compare.
        @(negedge clk);
        i16.in_valid = 1'b1; i16.a = 16'h1234; i16.b = 16'h1234; i16.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        i16.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midscan_rst_valid", {31'b0, i16.out_valid}, 32'd0);
        chk("midscan_rst_result", {29'b0, i16.lt, i16.eq, i16.gt}, 32'd0);
        chk("midscan_rst_in_ready", {31'b0, i16.in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("after_rst_no_valid", {31'b0, i16.out_valid}, 32'd0);
        end
        txn16(16'h00A1, 16'h00A7, 1'b0, 0, 1'b0, "after_rst");

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            sh = 4 * $urandom_range(1, 4);
            m  = 16'((32'd1 << sh) - 1);
            rb = ($urandom_range(0, 5) == 0) ? ra : (ra ^ (16'($urandom) & m));
            txn16(ra, rb, 1'($urandom), $urandom_range(0, 2), 1'($urandom), $sformatf("rnd16_%0d", i));
        end

        txn4(4'd0, 4'd0, 1'b0, "w4_0_0");
        txn4(4'd2, 4'd0, 1'b0, "w4_2_0");
        txn4(4'd3, 4'd1, 1'b0, "w4_3_1");
        txn4(4'd4, 4'd6, 1'b0, "w4_4_6");
        txn4(4'd3, 4'd2, 1'b0, "w4_3_2");
        txn4(4'd8, 4'd1, 1'b1, "w4_signed_8_1");
        for (int i = 0; i < 8; i++)
            txn4(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("rnd4_%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
